// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8 -- 8-way round-robin arbiter with a bounded hold time.
//
// One requester at a time owns a shared resource. The grant is registered, so
// it is visible one clock after the request is sampled. The holder keeps the
// grant until it asserts done, drops its request, or the hold counter expires.
// After every release the arbiter spends one IDLE cycle before granting again.
// The search for the next owner starts just after the previous owner, which
// bounds the wait of any continuously requesting requester to 7 other grants.
//
// Parameters
//   HOLD_MAX  maximum consecutive cycles one grant may be held (1..255);
//             0 disables the timeout entirely.
//
// Ports
//   clk      single clock, all state changes on its rising edge
//   rst_n    asynchronous active-low reset
//   req      request per requester, bit i = requester i
//   done     current holder releases the resource (ignored while idle)
//   gnt      registered one-hot grant, all-zero when nobody owns the resource
//   gnt_id   index of the granted requester, 0 when gnt is zero
//   busy     OR of gnt
//   any_req  combinational OR of req
//   timeout  one-cycle registered pulse after a release forced by expiry alone
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       any_req,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The counter value seen in the last permitted grant cycle. Counting starts
  // at 0 in the first grant cycle, so HOLD_MAX cycles end with HOLD_MAX-1.
  localparam bit         HOLD_EN   = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] gnt_d;
  logic [2:0] gnt_id_d;
  logic       timeout_d;

  logic       pick_valid;
  logic [2:0] pick_id;
  logic       holder_req;
  logic       expire;
  logic       release_now;

  assign any_req = |req;
  assign busy    = |gnt;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan last+1 .. last+8 (mod 8) and take the first hit.
  // The eighth candidate is last itself, so a lone requester is re-granted.
  // ---------------------------------------------------------------------------
  always_comb begin : pick_search
    logic [2:0] cand;
    // NOTE: every variable written in a combinational block gets a default
    // before any branch; a path that leaves one unassigned infers a latch.
    pick_valid = 1'b0;
    pick_id    = 3'd0;
    cand       = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Release conditions while a grant is held. Several may be true together;
  // they all collapse into one release.
  assign holder_req  = req[gnt_id];
  assign expire      = HOLD_EN && (hold_q == HOLD_LAST);
  assign release_now = done || !holder_req || expire;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req)     state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. gnt, gnt_id and timeout are registered so
  // they are glitch-free and line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_d     = gnt;
    gnt_id_d  = gnt_id;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (pick_valid) begin
          gnt_d    = 8'b1 << pick_id;
          gnt_id_d = pick_id;
          last_d   = pick_id;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_d     = 8'd0;
          gnt_id_d  = 3'd0;
          hold_d    = 8'd0;
          // Pulse only when expiry is the sole reason for the release.
          timeout_d = expire && !done && holder_req;
        end else begin
          // With the timeout disabled the counter simply wraps; it is never
          // compared, so wrapping is harmless.
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        gnt_d    = 8'd0;
        gnt_id_d = 3'd0;
        hold_d   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every control register is reset; last starts at 7 so that
      // requester 0 is first in search order after reset.
      gnt     <= 8'd0;
      gnt_id  <= 3'd0;
      last_q  <= 3'd7;
      hold_q  <= 8'd0;
      timeout <= 1'b0;
    end else begin
      gnt     <= gnt_d;
      gnt_id  <= gnt_id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      timeout <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt));

  a_id_match: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt == 8'd0) ? (gnt_id == 3'd0) : gnt[gnt_id]);

  a_state_match: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT) == (gnt != 8'd0));
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// Bench for rr_arbiter8. Three instances share stimulus: the default HOLD_MAX,
// HOLD_MAX=4 and HOLD_MAX=0. Every sequence starts from reset so all three are
// in the same state; each sequence compares the instance whose parameter it
// exercises. Vectors are {req, done, expected gnt, expected timeout} per
// cycle; expectations go into a scoreboard when driven and are popped and
// compared one clock later, after the registered outputs have updated.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;

  logic [7:0] gnt_o     [3];
  logic [2:0] gnt_id_o  [3];
  logic       busy_o    [3];
  logic       any_req_o [3];
  logic       timeout_o [3];

  localparam int D16 = 0;
  localparam int D4  = 1;
  localparam int D0  = 2;

  rr_arbiter8 dut16 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_o[D16]), .gnt_id(gnt_id_o[D16]), .busy(busy_o[D16]),
    .any_req(any_req_o[D16]), .timeout(timeout_o[D16])
  );

  rr_arbiter8 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_o[D4]), .gnt_id(gnt_id_o[D4]), .busy(busy_o[D4]),
    .any_req(any_req_o[D4]), .timeout(timeout_o[D4])
  );

  rr_arbiter8 #(.HOLD_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt_o[D0]), .gnt_id(gnt_id_o[D0]), .busy(busy_o[D0]),
    .any_req(any_req_o[D0]), .timeout(timeout_o[D0])
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       timeout;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic       timeout;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   sel    = D16;

  function automatic vec_t mk(logic [7:0] r, logic d, logic [7:0] g, logic t);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.timeout = t;
    return v;
  endfunction

  function automatic logic [2:0] idx_of(logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input int k);
    check({name, " gnt"},     32'(gnt_o[k]),     32'h0);
    check({name, " gnt_id"},  32'(gnt_id_o[k]),  32'h0);
    check({name, " busy"},    32'(busy_o[k]),    32'h0);
    check({name, " timeout"}, 32'(timeout_o[k]), 32'h0);
  endtask

  // Drive one cycle of stimulus on the falling edge and check the registered
  // outputs just after the following rising edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    req  = v.req;
    done = v.done;
    e.gnt = v.gnt; e.timeout = v.timeout; e.tag = tag;
    sb.push_back(e);
    #1;
    check({tag, " any_req"}, 32'(any_req_o[sel]), 32'(|v.req));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check({e.tag, " gnt"},     32'(gnt_o[sel]),     32'(e.gnt));
      check({e.tag, " gnt_id"},  32'(gnt_id_o[sel]),  32'(idx_of(e.gnt)));
      check({e.tag, " busy"},    32'(busy_o[sel]),    32'(|e.gnt));
      check({e.tag, " timeout"}, 32'(timeout_o[sel]), 32'(e.timeout));
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'd0;
    done  = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check_idle($sformatf("%s dut%0d", name, k), k);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // ---- reset state ------------------------------------------------------
    do_reset("reset");

    // ---- two requesters alternate, done one cycle into each grant --------
    sel = D16;
    tbl.push_back(mk(8'h81, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mk(8'h81, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h81, 1'b0, 8'h80, 1'b0));
    tbl.push_back(mk(8'h81, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h81, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mk(8'h81, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    run_table("alt81");

    // ---- all requesting, done always high (also ignored in IDLE) ---------
    do_reset("reset_ff");
    for (int i = 0; i < 9; i++) begin
      tbl.push_back(mk(8'hFF, 1'b1, 8'h01 << (i % 8), 1'b0));
      tbl.push_back(mk(8'hFF, 1'b1, 8'h00, 1'b0));
    end
    run_table("rotate");

    // ---- other req bits ignored, drop release, done+drop together --------
    do_reset("reset_drop");
    tbl.push_back(mk(8'h08, 1'b0, 8'h08, 1'b0));
    tbl.push_back(mk(8'h0F, 1'b0, 8'h08, 1'b0));
    tbl.push_back(mk(8'h18, 1'b0, 8'h08, 1'b0));
    tbl.push_back(mk(8'h10, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h10, 1'b0, 8'h10, 1'b0));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h08, 1'b0, 8'h08, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    run_table("drop");

    // ---- HOLD_MAX=4: expiry, expiry with done, expiry with drop ----------
    do_reset("reset_h4");
    sel = D4;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h04, 1'b0, 8'h04, 1'b0));
      tbl.push_back(mk(8'h04, 1'b0, 8'h00, 1'b1));
    end
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h04, 1'b0, 8'h04, 1'b0));
    tbl.push_back(mk(8'h04, 1'b1, 8'h00, 1'b0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h04, 1'b0, 8'h04, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0));
    run_table("hold4");

    // ---- default HOLD_MAX=16 expiry --------------------------------------
    do_reset("reset_h16");
    sel = D16;
    for (int i = 0; i < 16; i++) tbl.push_back(mk(8'h40, 1'b0, 8'h40, 1'b0));
    tbl.push_back(mk(8'h40, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mk(8'h40, 1'b0, 8'h40, 1'b0));
    run_table("hold16");

    // ---- HOLD_MAX=0: never times out -------------------------------------
    do_reset("reset_h0");
    sel = D0;
    for (int i = 0; i < 300; i++) tbl.push_back(mk(8'h02, 1'b0, 8'h02, 1'b0));
    run_table("hold0");

    // ---- reset mid-grant of requester 5 ----------------------------------
    do_reset("reset_mid");
    sel = D16;
    tbl.push_back(mk(8'h21, 1'b1, 8'h01, 1'b0));
    tbl.push_back(mk(8'h21, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h21, 1'b0, 8'h20, 1'b0));
    tbl.push_back(mk(8'h21, 1'b0, 8'h20, 1'b0));
    run_table("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst", D16);
    @(posedge clk);
    #1;
    check_idle("held_rst", D16);
    @(negedge clk);
    rst_n = 1'b1;
    tbl.push_back(mk(8'h21, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mk(8'h21, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mk(8'h21, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mk(8'h21, 1'b0, 8'h20, 1'b0));
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: maximum consecutive cycles one grant may be held (1..255); 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  8  request per requester; bit i = requester i.
REQ-005 SHALL have port done  input  1  current grant holder releases the shared resource.
REQ-006 SHALL have port gnt  output  8  one-hot grant, registered; all-zero when no grant.
REQ-007 SHALL have port gnt_id  output  3  index of the granted requester; 0 when gnt is zero.
REQ-008 SHALL have port busy  output  1  OR-reduction of gnt.
REQ-009 SHALL have port any_req  output  1  combinational OR-reduction of req.
REQ-010 SHALL have port timeout  output  1  one-cycle registered pulse marking a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (exactly one gnt bit set).
REQ-012 SHALL hold a 3-bit last-grant pointer `last`; the search order is last+1, last+2, ... last+8, modulo 8.
REQ-013 In IDLE, when any_req=1 at a rising edge, SHALL move to GRANT, setting gnt to the first requesting index in search order, setting gnt_id to that index, and setting `last` to that index.
REQ-014 In IDLE with any_req=0, SHALL stay in IDLE; done SHALL be ignored in IDLE.
REQ-015 Grant latency SHALL be exactly one edge: a req sampled at edge N gives gnt visible after edge N.
REQ-016 In GRANT, SHALL release (next state IDLE, gnt=0) at an edge where any of these holds: done=1; req[gnt_id]=0; or the hold counter expires.
REQ-017 The hold counter SHALL be 8 bits, cleared on entering GRANT, and incremented each GRANT cycle; it expires when gnt has been high for HOLD_MAX cycles, so gnt is never high for more than HOLD_MAX consecutive cycles.
REQ-018 timeout SHALL be 1 for exactly the first IDLE cycle after a release caused only by counter expiry; it SHALL be 0 when done=1 or the req drop coincides with expiry.
REQ-019 After every release, SHALL spend exactly one IDLE cycle before the next grant (no back-to-back grants).
REQ-020 Simultaneous done=1 and req[gnt_id]=0 SHALL produce a single release.
REQ-021 Changes on req bits other than gnt_id during GRANT SHALL NOT affect the grant.
REQ-022 A requester still requesting after release SHALL be granted again only when no other requester lies earlier in search order (fairness: at most 7 other grants between two grants to a continuously requesting requester).
REQ-023 busy and gnt_id SHALL be consistent with gnt in every cycle; gnt SHALL never have more than one bit set.

Reset
REQ-024 While rst_n=0, asynchronously and immediately: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, last=7 (requester 0 has first priority after reset).
REQ-025 Reset asserted mid-grant SHALL drop gnt without a timeout pulse; the first edge after rst_n rises SHALL arbitrate as in REQ-013.

Verification
REQ-026 Reset, then req=8'h81 held, done pulsed 1 cycle after each grant -> gnt=8'h01, then 8'h00 for 1 cycle, then 8'h80, then 8'h00, then 8'h01.
REQ-027 req=8'hFF held, done=1 every GRANT cycle -> gnt_id sequence 0,1,2,...,7,0, with gnt=0 between each grant; busy matches gnt.
REQ-028 HOLD_MAX=4, req=8'h04 held, done=0 -> gnt=8'h04 for exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt=8'h04 again.
REQ-029 Grant to req[3], then req=8'h00 (drop) with done=0 -> gnt=0 on the next edge, timeout=0; any_req=0 in the same cycle the drop is applied.
REQ-030 rst_n pulsed low mid-grant of requester 5 with req=8'h21 -> gnt=0 immediately; after release of reset, gnt=8'h01 first (not 8'h20).
REQ-031 HOLD_MAX=0, req=8'h02 held for 300 cycles -> gnt=8'h02 continuously, timeout never asserted.
